// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared types and helpers for the pipelined barrel shifter and its
// fixed-amount shift stages.
//   shift_dir_t  : direction encoding carried with every transaction
//   shamt_width(): shift-amount width for a given data width
// -----------------------------------------------------------------------------
package shifter_pkg;

  typedef enum logic {
    SHIFT_RIGHT = 1'b0,
    SHIFT_LEFT  = 1'b1
  } shift_dir_t;

  // Width of a shift amount able to express 0..n-1 (at least one bit).
  function automatic int shamt_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/fixed_shift_stage.sv
// -----------------------------------------------------------------------------
// fixed_shift_stage
// Combinational shift by a constant amount S, or pass-through when disabled.
// Ports:
//   i_data   [N-1:0] word entering the stage
//   i_enable         1 = shift by S, 0 = pass i_data unchanged
//   i_dir            0 = right, 1 = left
//   i_arith          right shifts only: 1 = fill with i_data[N-1], 0 = zeros
//   o_data   [N-1:0] shifted (or unchanged) word
// Left shifts always zero-fill. S must lie in 1..N-1.
// -----------------------------------------------------------------------------
module fixed_shift_stage
  import shifter_pkg::*;
#(
  parameter int N = 8,
  parameter int S = 1
) (
  input  logic [N-1:0] i_data,
  input  logic         i_enable,
  input  logic         i_dir,
  input  logic         i_arith,
  output logic [N-1:0] o_data
);

  logic w_fill;

  // The MSB survives every arithmetic stage, so the local MSB is the
  // original sign bit.
  assign w_fill = i_arith & i_data[N-1];

  // Select pass-through, left shift or right shift by the constant S.
  always_comb begin
    o_data = i_data;
    if (!i_enable) begin
      o_data = i_data;
    end else if (shift_dir_t'(i_dir) == SHIFT_LEFT) begin
      o_data = {i_data[N-1-S:0], {S{1'b0}}};
    end else begin
      o_data = {{S{w_fill}}, i_data[N-1:S]};
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
// Variable-amount barrel shifter, one registered stage per shift-amount bit.
// Stage k shifts by 2^k when bit k of the carried shift amount is set.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   up_valid/up_ready   input handshake
//   up_data  [N-1:0]    word to shift
//   up_shamt [SW-1:0]   shift amount 0..N-1
//   up_dir              0 = right, 1 = left
//   up_arith            right shifts: 1 = sign fill, 0 = zero fill
//   down_valid/ready    output handshake
//   down_data [N-1:0]   shifted word (registered)
// Latency is STAGES cycles; full throughput; a stalled pipe holds STAGES
// transactions and compacts bubbles.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      up_valid,
  output logic                      up_ready,
  input  logic [N-1:0]              up_data,
  input  logic [shamt_width(N)-1:0] up_shamt,
  input  logic                      up_dir,
  input  logic                      up_arith,
  output logic                      down_valid,
  input  logic                      down_ready,
  output logic [N-1:0]              down_data
);

  localparam int SW     = shamt_width(N);
  localparam int STAGES = SW;
  localparam int LAST   = STAGES - 1;

  // Per-stage pipeline registers.
  logic [STAGES-1:0]         r_valid;
  logic [STAGES-1:0][N-1:0]  r_data;
  logic [STAGES-1:0][SW-1:0] r_shamt;
  logic [STAGES-1:0]         r_dir;
  logic [STAGES-1:0]         r_arith;

  // Per-stage inputs, shifter outputs and load enables.
  logic [STAGES-1:0]         w_load;
  logic [STAGES-1:0]         w_in_valid;
  logic [STAGES-1:0][N-1:0]  w_in_data;
  logic [STAGES-1:0][SW-1:0] w_in_shamt;
  logic [STAGES-1:0]         w_in_dir;
  logic [STAGES-1:0]         w_in_arith;
  logic [STAGES-1:0][N-1:0]  w_shifted;
  logic                      w_unused_sideband;

  // Load-enable chain: stage k may load when downstream drains or when
  // any stage from k to the output is empty (a hole lets everything
  // upstream of it shuffle forward). Written as a prefix AND so the
  // enables do not depend on each other.
  always_comb begin
    logic w_all_full;
    w_all_full = 1'b1;
    w_load     = '0;
    for (int k = LAST; k >= 0; k--) begin
      w_all_full = w_all_full & r_valid[k];
      w_load[k]  = down_ready | ~w_all_full;
    end
  end

  // Stage inputs: stage 0 takes the upstream port, later stages take the
  // registers of the stage before.
  always_comb begin
    w_in_valid    = '0;
    w_in_data     = '0;
    w_in_shamt    = '0;
    w_in_dir      = '0;
    w_in_arith    = '0;
    w_in_valid[0] = up_valid;
    w_in_data[0]  = up_data;
    w_in_shamt[0] = up_shamt;
    w_in_dir[0]   = up_dir;
    w_in_arith[0] = up_arith;
    for (int k = 1; k < STAGES; k++) begin
      w_in_valid[k] = r_valid[k-1];
      w_in_data[k]  = r_data[k-1];
      w_in_shamt[k] = r_shamt[k-1];
      w_in_dir[k]   = r_dir[k-1];
      w_in_arith[k] = r_arith[k-1];
    end
  end

  // One fixed-amount shifter per stage, stage k shifting by 2^k.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    fixed_shift_stage #(
      .N (N),
      .S (1 << k)
    ) u_shift (
      .i_data   (w_in_data[k]),
      .i_enable (w_in_shamt[k][k]),
      .i_dir    (w_in_dir[k]),
      .i_arith  (w_in_arith[k]),
      .o_data   (w_shifted[k])
    );
  end

  // Pipeline registers: reset clears everything, otherwise each stage
  // captures its shifted input whenever its load enable is high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
      r_shamt <= '0;
      r_dir   <= '0;
      r_arith <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_valid[k] <= w_in_valid[k];
          r_data[k]  <= w_shifted[k];
          r_shamt[k] <= w_in_shamt[k];
          r_dir[k]   <= w_in_dir[k];
          r_arith[k] <= w_in_arith[k];
        end
      end
    end
  end

  assign up_ready   = w_load[0];
  assign down_valid = r_valid[LAST];
  assign down_data  = r_data[LAST];

  // The last stage's sideband travels with the result but has no consumer.
  assign w_unused_sideband = ^{r_shamt[LAST], r_dir[LAST], r_arith[LAST]};

endmodule
